shift_sequencer: RTL and testbench

//  Multi-position shift controller wrapped around the ALU's 1-position shifter.

---
 rtl/shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_shift_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: builds a multi-position logical shift out of a
// single-position shifter. The operand is sent to the shifter once per step,
// and each answer is fed back as the next operand until the requested number
// of steps is done.
// Optional build macro: SHIFT_SEQ_STATUS_EN adds the carry and zero outputs.
module shift_sequencer #(
    parameter int WIDTH     = 16,
    parameter int AMT_W     = 4,
    parameter int SHIFT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sh_A,
    output logic             sh_Control,
`ifdef SHIFT_SEQ_STATUS_EN
    output logic             carry,
    output logic             zero,
`endif
    input  logic [WIDTH-1:0] sh_Answer
);

    // The wait counter only needs to hold SHIFT_LAT-1 and must be at least one bit wide.
    localparam int LAT_W = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;
    localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'(SHIFT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        WAIT,
        FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] result_q;
    logic             ctrl_q;
    logic             busy_q;
    logic             done_q;
    logic [AMT_W-1:0] count_q;
    logic [AMT_W-1:0] count_d;
    logic [LAT_W-1:0] wait_q;

`ifdef SHIFT_SEQ_STATUS_EN
    logic             carry_q;
    logic             zero_q;
    logic             carry_step_q;
    logic             carry_step_d;
`endif

    // The remaining step count after the step now being captured.
    always_comb begin
        count_d = count_q - AMT_W'(1);
    end

`ifdef SHIFT_SEQ_STATUS_EN
    // The bit that the current single-position step pushes out of the operand.
    always_comb begin
        carry_step_d = ctrl_q ? sh_a_q[0] : sh_a_q[WIDTH-1];
    end
`endif

    // Sequencer FSM: accepts a request when idle, alternates between presenting the
    // operand and waiting for the shifter answer, then publishes the result for one cycle.
    // A start during the done cycle is dropped, so back-to-back requests begin one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            result_q <= '0;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            wait_q   <= '0;
`ifdef SHIFT_SEQ_STATUS_EN
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            carry_step_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        sh_a_q  <= data_in;
                        ctrl_q  <= dir;
                        count_q <= amount;
                        busy_q  <= 1'b1;
`ifdef SHIFT_SEQ_STATUS_EN
                        carry_step_q <= 1'b0;
`endif
                        state_q <= (amount == '0) ? FIN : STEP;
                    end
                end
                STEP: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        sh_a_q  <= sh_Answer;
                        count_q <= count_d;
`ifdef SHIFT_SEQ_STATUS_EN
                        carry_step_q <= carry_step_d;
`endif
                        state_q <= (count_d == '0) ? FIN : STEP;
                    end else begin
                        wait_q <= wait_q - LAT_W'(1);
                    end
                end
                FIN: begin
                    result_q <= sh_a_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
`ifdef SHIFT_SEQ_STATUS_EN
                    carry_q <= carry_step_q;
                    zero_q  <= (sh_a_q == '0);
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign sh_A       = sh_a_q;
    assign sh_Control = ctrl_q;
`ifdef SHIFT_SEQ_STATUS_EN
    assign carry      = carry_q;
    assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer with a registered one-cycle shifter model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [3:0]  amount;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] sh_A;
    logic        sh_Control;
    logic [15:0] sh_Answer = 16'h0000;
`ifdef SHIFT_SEQ_STATUS_EN
    logic        carry;
    logic        zero;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4), .SHIFT_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .amount     (amount),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sh_A       (sh_A),
        .sh_Control (sh_Control),
`ifdef SHIFT_SEQ_STATUS_EN
        .carry      (carry),
        .zero       (zero),
`endif
        .sh_Answer  (sh_Answer)
    );

    always #5 clk = ~clk;

    // One-position logical shifter whose answer is valid one clock after its input.
    always @(posedge clk) begin
        sh_Answer <= sh_Control ? (sh_A >> 1) : (sh_A << 1);
    end

    task automatic start_op(input logic [15:0] d, input logic dr, input logic [3:0] amt);
        @(negedge clk);
        data_in = d;
        dir     = dr;
        amount  = amt;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; amount = 4'd0; data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if ({busy, done, sh_Control} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got busy/done/ctrl=%b expected 000", {busy, done, sh_Control});
        end
        testsRun++;
        if (result !== 16'h0000 || sh_A !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got result=%h sh_A=%h expected 0000 0000", result, sh_A);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_left1();
        int c;
        start_op(16'd10, 1'b0, 4'd1);
        data_in = 16'hFFFF; dir = 1'b1; amount = 4'd7;
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL left1_busy: got %b expected 1", busy);
        end
        wait_done(c);
        testsRun++;
        if (c !== 3) begin
            testsFailed++;
            $display("[TB] FAIL left1_latency: got %0d expected 3", c);
        end
        testsRun++;
        if (result !== 16'd20 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL left1_result: got %h busy=%b expected 0014 busy=0", result, busy);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (done !== 1'b0 || result !== 16'd20) begin
            testsFailed++;
            $display("[TB] FAIL left1_pulse: got done=%b result=%h expected 0 0014", done, result);
        end
    endtask

    task automatic test_right1();
        int c;
        start_op(16'd9, 1'b1, 4'd1);
        testsRun++;
        if (sh_Control !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL right1_ctrl: got %b expected 1", sh_Control);
        end
        wait_done(c);
        testsRun++;
        if (c !== 3 || result !== 16'd4) begin
            testsFailed++;
            $display("[TB] FAIL right1_result: got %h after %0d expected 0004 after 3", result, c);
        end
`ifdef SHIFT_SEQ_STATUS_EN
        testsRun++;
        if (carry !== 1'b1 || zero !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL right1_status: got c=%b z=%b expected 1 0", carry, zero);
        end
`endif
        @(posedge clk);
        start_op(16'h0001, 1'b1, 4'd1);
        wait_done(c);
        testsRun++;
        if (result !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL right1_tozero: got %h expected 0000", result);
        end
`ifdef SHIFT_SEQ_STATUS_EN
        testsRun++;
        if (carry !== 1'b1 || zero !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL right1_zero: got c=%b z=%b expected 1 1", carry, zero);
        end
`endif
        @(posedge clk);
    endtask

    task automatic test_long();
        int c;
        start_op(16'h8001, 1'b0, 4'd15);
        wait_done(c);
        testsRun++;
        if (c !== 31) begin
            testsFailed++;
            $display("[TB] FAIL long_latency: got %0d expected 31", c);
        end
        testsRun++;
        if (result !== 16'h8000) begin
            testsFailed++;
            $display("[TB] FAIL long_result: got %h expected 8000", result);
        end
`ifdef SHIFT_SEQ_STATUS_EN
        testsRun++;
        if (carry !== 1'b0 || zero !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL long_status: got c=%b z=%b expected 0 0", carry, zero);
        end
`endif
        @(posedge clk);
    endtask

    task automatic test_zero_amount();
        int c;
        start_op(16'h1234, 1'b1, 4'd0);
        wait_done(c);
        testsRun++;
        if (c !== 1 || result !== 16'h1234) begin
            testsFailed++;
            $display("[TB] FAIL zeroamt_result: got %h after %0d expected 1234 after 1", result, c);
        end
`ifdef SHIFT_SEQ_STATUS_EN
        testsRun++;
        if (carry !== 1'b0 || zero !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL zeroamt_status: got c=%b z=%b expected 0 0", carry, zero);
        end
`endif
        @(posedge clk);
    endtask

    task automatic test_ignore_busy();
        int c;
        start_op(16'h0003, 1'b0, 4'd3);
        @(negedge clk);
        start = 1'b1; data_in = 16'hFFFF; dir = 1'b1; amount = 4'd1;
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        testsRun++;
        if (c !== 7 || result !== 16'h0018) begin
            testsFailed++;
            $display("[TB] FAIL ignore_result: got %h after %0d expected 0018 after 7", result, c);
        end
        testsRun++;
        if (sh_Control !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_ctrl: got %b expected 0", sh_Control);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int c;
        logic sawDone;
        start_op(16'h0001, 1'b0, 4'd5);
        repeat (4) @(posedge clk);
        #1;
        testsRun++;
        if (sh_A !== 16'h0004) begin
            testsFailed++;
            $display("[TB] FAIL midrst_progress: got %h expected 0004", sh_A);
        end
        rst = 1'b1;
        #2;
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || sh_A !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL midrst_clear: got busy=%b done=%b result=%h sh_A=%h expected 0 0 0000 0000",
                     busy, done, result, sh_A);
        end
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) sawDone = 1'b1;
        end
        testsRun++;
        if (sawDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_nodone: got done seen=%b expected 0", sawDone);
        end
        start_op(16'h0005, 1'b1, 4'd2);
        wait_done(c);
        testsRun++;
        if (c !== 5 || result !== 16'h0001) begin
            testsFailed++;
            $display("[TB] FAIL midrst_restart: got %h after %0d expected 0001 after 5", result, c);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        @(posedge clk);
        start_op(16'h00F0, 1'b1, 4'd4);
        wait_done(c);
        testsRun++;
        if (c !== 9 || result !== 16'h000F) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first: got %h after %0d expected 000F after 9", result, c);
        end
        @(negedge clk);
        start = 1'b1; data_in = 16'h0101; dir = 1'b0; amount = 4'd2;
        @(posedge clk);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_duringdone: got busy=%b expected 0", busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        wait_done(c);
        testsRun++;
        if (c !== 5 || result !== 16'h0404) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second: got %h after %0d expected 0404 after 5", result, c);
        end
    endtask

    initial begin
        test_reset();
        test_left1();
        test_right1();
        test_long();
        test_zero_amount();
        test_ignore_busy();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
